// File: rtl/alu_seq_sliced.sv
// Multi-cycle ALU: processes a WIDTH-bit operation one SLICE-bit chunk per clock,
// LSB slice first, chaining the carry between slices; valid/ready on both sides.
module alu_seq_sliced #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       s,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             z,
    output logic             c,
    output logic             v,
    output logic             n
);
    localparam int N     = WIDTH / SLICE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc;
    logic [2:0]       s_reg;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic [IDX_W-1:0] base;
    logic [SLICE-1:0] a_sl;
    logic [SLICE-1:0] b_sl;
    logic [SLICE-1:0] x_sl;
    logic [SLICE-1:0] y_sl;
    logic [SLICE-1:0] r_sl;
    logic [SLICE:0]   sum_sl;
    logic             arith;
    logic             last;
    logic             msb_carry_in;
    logic [WIDTH-1:0] assembled;

    // One slice of the datapath; subtraction is addition of the inverted operand.
    always_comb begin
        base   = IDX_W'(32'(cnt) * SLICE);
        a_sl   = a_reg[base +: SLICE];
        b_sl   = b_reg[base +: SLICE];
        arith  = (s_reg == 3'b001) || (s_reg == 3'b010) || (s_reg == 3'b011);
        x_sl   = a_sl;
        y_sl   = b_sl;
        case (s_reg)
            3'b001: begin
                x_sl = b_sl;
                y_sl = ~a_sl;
            end
            3'b010: y_sl = ~b_sl;
            default: ;
        endcase
        sum_sl = {1'b0, x_sl} + {1'b0, y_sl} + {{SLICE{1'b0}}, carry};
        // Carry into the slice MSB recovered from the sum bit; on the last slice this is bit WIDTH-1.
        msb_carry_in = x_sl[SLICE-1] ^ y_sl[SLICE-1] ^ sum_sl[SLICE-1];
        case (s_reg)
            3'b000:  r_sl = '0;
            3'b100:  r_sl = a_sl ^ b_sl;
            3'b101:  r_sl = a_sl | b_sl;
            3'b110:  r_sl = a_sl & b_sl;
            3'b111:  r_sl = '1;
            default: r_sl = sum_sl[SLICE-1:0];
        endcase
        assembled = acc;
        assembled[base +: SLICE] = r_sl;
        last = (cnt == LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Visible result only updates on the final slice, so no partial value ever leaks out.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            s_reg <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            f     <= '0;
            z     <= 1'b0;
            c     <= 1'b0;
            v     <= 1'b0;
            n     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b;
                        s_reg <= s;
                        carry <= cin;
                        cnt   <= '0;
                    end
                end
                BUSY: begin
                    acc   <= assembled;
                    carry <= sum_sl[SLICE];
                    cnt   <= cnt + CNT_W'(1);
                    if (last) begin
                        f <= assembled;
                        z <= (assembled == '0);
                        n <= assembled[WIDTH-1];
                        c <= arith & sum_sl[SLICE];
                        v <= arith & (msb_carry_in ^ sum_sl[SLICE]);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_seq_sliced.md
Name: alu_seq_sliced

Overview:
- Parametrised, multi-cycle ALU; successor to the 4-bit 381-style function slice.
- Processes a WIDTH-bit operation one SLICE-bit chunk per clock, LSB slice first, with the carry chained between slices.
- Keeps the 8-function select encoding; adds a valid/ready handshake on input and output, result holding under back-pressure, and full-width Z/C/V/N flags.
- Sits between the register-file read stage and writeback in the homebrew RISC-V datapath.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of SLICE.
- SLICE, 4, bits processed per cycle; 1 <= SLICE <= WIDTH.
- (derived) N = WIDTH/SLICE, slices per operation.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept a bundle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- s  in  3  function select.
- cin  in  1  carry-in for arithmetic ops.
- out_valid  out  1  result and flags valid.
- out_ready  in  1  consumer accepts the result.
- f  out  WIDTH  result.
- z  out  1  zero flag (f == 0).
- c  out  1  carry-out of the MSB (arithmetic ops only, else 0).
- v  out  1  signed overflow (arithmetic ops only, else 0).
- n  out  1  f[WIDTH-1].

Behaviour:
- Reset and synchronicity: one clock, clk; reset is synchronous and active-high, port rst.
- Reset values: state IDLE; in_ready=1; out_valid=0; f, z, c, v, n all 0; slice counter 0; internal carry 0.
- Reset mid-operation: the operation is discarded and the reset values above apply on the next edge. No partial result is ever presented.
- Functions, two's complement, full WIDTH:
  - 000: f = 0.
  - 001: f = B + ~A + cin (B-A, borrow-free when cin=1).
  - 010: f = A + ~B + cin.
  - 011: f = A + B + cin.
  - 100: A^B.
  - 101: A|B.
  - 110: A&B.
  - 111: f = all ones.
- C and V for arithmetic ops (001, 010, 011):
  - C = carry out of bit WIDTH-1. For subtraction, C=1 means no borrow.
  - V = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- States and transitions:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a, b, s, cin; set the internal carry to cin and the counter to 0; go to BUSY.
  - BUSY: in_ready=0. Each edge computes slice k = bits [k*SLICE +: SLICE] using the latched carry, stores the slice result, updates the carry, then increments k. On the edge that computes slice N-1, go to DONE.
  - DONE: out_valid=1; f and flags are stable. On out_valid&&out_ready, go to IDLE with out_valid=0.
- Latency: out_valid rises exactly N edges after the accepting edge (8 for the defaults; 1 when SLICE=WIDTH).
- Throughput: one operation per N+2 cycles. in_ready is never asserted in BUSY or DONE.
- Back-pressure: while out_ready=0 in DONE, f, z, c, v and n hold their values indefinitely.
- Inputs a, b, s and cin are don't-care outside the accepting edge; changes on them never affect an operation in flight.
- In IDLE, f and the flags retain the last delivered result (0 after reset).
- Carry chain: the carry passes between slices for every op. For logic ops and ops 000/111 it is ignored and c=v=0.
- z is computed over the full assembled WIDTH-bit result, never per slice.

Test Plan:
- Defaults, s=011, a=0xFFFFFFFF, b=0x00000001, cin=0 → out_valid exactly 8 cycles after accept; f=0x00000000, z=1, c=1, v=0, n=0.
- s=011, a=0x7FFFFFFF, b=0x00000001, cin=0 → f=0x80000000, v=1, n=1, c=0, z=0.
- s=010, a=5, b=7, cin=1 → f=0xFFFFFFFE, c=0 (borrow), n=1. Then s=001 with the same operands → f=0x00000002, c=1.
- Logic ops: s=100/101/110 with a=0xF0F0A5A5, b=0x0FF0FFFF → f=0xFF005A5A / 0xFFF0FFFF / 0x00F0A5A5, c=v=0. s=111 → 0xFFFFFFFF; s=000 → 0 with z=1.
- Back-pressure and handshake:
  - Hold out_ready=0 for 10 cycles after out_valid → f and flags unchanged, in_ready=0 throughout, and a new in_valid is not accepted.
  - Release out_ready → in_ready=1 the next cycle.
- Assert rst during BUSY at slice 3 → next cycle state IDLE, out_valid=0, f=0. A following op completes correctly. Repeat all cases with WIDTH=8/SLICE=8 (latency 1) and WIDTH=12/SLICE=3 (latency 4).
